// File: rtl/glitch_filter.sv
// Two-channel glitch filter: a channel's filtered output changes only after the raw input has held a new value for MIN_STABLE samples.
// Optional feature: define GLITCH_SYNC_EN to put a 2-flop synchronizer on each y_i bit ahead of the filter.
module glitch_filter #(
  parameter int MIN_STABLE = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       y_i,
  input  logic             clr_i,
  output logic [1:0]       filt_o,
  output logic [1:0]       glitch_o,
  output logic [CNT_W-1:0] gcnt0_o,
  output logic [CNT_W-1:0] gcnt1_o
);

  localparam int RUN_W = $clog2(MIN_STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [1:0] samp;

`ifdef GLITCH_SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= y_i;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = y_i;
`endif

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             filt_q, filt_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // run_q counts consecutive samples that disagree with the accepted value.
    always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      filt_d   = filt_q;
      glitch_d = 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (samp[ch] != filt_q) begin
            state_d = ST_PENDING;
            run_d   = RUN_W'(1);
          end
        end
        ST_PENDING: begin
          if (samp[ch] == filt_q) begin
            state_d  = ST_STABLE;
            run_d    = '0;
            glitch_d = 1'b1;
          end else if (run_q == RUN_LAST) begin
            state_d = ST_STABLE;
            run_d   = '0;
            filt_d  = samp[ch];
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          run_d   = '0;
        end
      endcase
    end

    // Clear wins over a coincident glitch; the count saturates instead of wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (glitch_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= ST_STABLE;
        run_q    <= '0;
        filt_q   <= 1'b0;
        glitch_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        state_q  <= state_d;
        run_q    <= run_d;
        filt_q   <= filt_d;
        glitch_q <= glitch_d;
        cnt_q    <= cnt_d;
      end
    end

    assign filt_o[ch]   = filt_q;
    assign glitch_o[ch] = glitch_q;
  end

  assign gcnt0_o = g_ch[0].cnt_q;
  assign gcnt1_o = g_ch[1].cnt_q;

endmodule

// File: doc/glitch_filter.md
GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 The module SHALL have parameter MIN_STABLE, default 3, legal range 2..15: the number of consecutive samples an input must hold before it is accepted.
REQ-002 The module SHALL have parameter CNT_W, default 8: the width of each glitch counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port y_i, input, 2 bits: the raw, possibly glitchy outputs y1,y0 of the combinational glitch circuit; bit n is channel n.
REQ-006 The module SHALL have port clr_i, input, 1 bit: synchronous clear of both glitch counters.
REQ-007 The module SHALL have port filt_o, output, 2 bits: the filtered, glitch-free value per channel.
REQ-008 The module SHALL have port glitch_o, output, 2 bits: a one-cycle strobe per channel when a glitch is rejected.
REQ-009 The module SHALL have port gcnt0_o, output, CNT_W bits: the rejected-glitch count for channel 0.
REQ-010 The module SHALL have port gcnt1_o, output, CNT_W bits: the rejected-glitch count for channel 1.

Function
REQ-011 Each channel SHALL run an independent FSM with states STABLE and PENDING, plus a run counter of $clog2(MIN_STABLE+1) bits.
REQ-012 STABLE: if sample == filt_o[n], the channel SHALL stay in STABLE; if they differ, it SHALL go to PENDING with run = 1.
REQ-013 PENDING with sample != filt_o[n] and run == MIN_STABLE-1: the channel SHALL set filt_o[n] <= sample, go to STABLE, and clear run.
REQ-014 PENDING with sample != filt_o[n] and run < MIN_STABLE-1: the channel SHALL increment run.
REQ-015 PENDING with sample == filt_o[n]: this is a glitch; the channel SHALL go to STABLE, clear run, and assert glitch_o[n] for exactly the next cycle (registered output).
REQ-016 On each glitch, the channel's counter SHALL increment by 1 and saturate at 2^CNT_W-1 (no wrap).
REQ-017 Latency: filt_o[n] SHALL change on the MIN_STABLE-th consecutive rising edge at which the sample differs from filt_o[n].
REQ-018 Any deviation shorter than MIN_STABLE samples SHALL never reach filt_o.
REQ-019 clr_i high SHALL set both counters to 0 on the next edge; clr_i SHALL take priority over a simultaneous glitch increment (result 0), but glitch_o SHALL still pulse.
REQ-020 Both channels changing, or glitching, on the same edge SHALL be handled independently, and both glitch_o bits SHALL be allowed high together.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from y_i to any output.

Reset
REQ-022 With rst high at a rising edge, the module SHALL set filt_o = 2'b00, glitch_o = 2'b00, both counters = 0, both FSMs = STABLE, and run = 0 (plus synchronizer flops = 0 when GLITCH_SYNC_EN is defined).
REQ-023 rst asserted mid-PENDING SHALL abandon the pending change with no glitch counted; rst SHALL override clr_i and all other inputs.
REQ-024 On the first edge after rst deasserts, the FSMs SHALL evaluate the sample against filt_o = 00.

Configuration
REQ-025 With macro GLITCH_SYNC_EN defined, y_i SHALL pass through a 2-flop synchronizer per bit before the FSM, adding exactly 2 cycles to all latencies in REQ-017 and REQ-015.
REQ-026 With GLITCH_SYNC_EN undefined, y_i SHALL be sampled directly by the FSM, and functional behaviour SHALL otherwise be identical.

Verification (MIN_STABLE=3, CNT_W=8, GLITCH_SYNC_EN undefined unless stated)
REQ-027 Step: y_i 00->01 held -> filt_o = 01 on the 3rd edge after the change; glitch_o stays 00; gcnt0_o = 0.
REQ-028 Glitch: y_i[0] high for 2 samples, then low -> filt_o stays 00; glitch_o = 01 for one cycle; gcnt0_o = 1.
REQ-029 Simultaneous: y_i 00->11 for 1 sample, then 00 -> glitch_o = 11 for one cycle; gcnt0_o = gcnt1_o = 1.
REQ-030 Saturation and clear: 260 channel-1 glitches -> gcnt1_o = 255; then clr_i coincident with a glitch -> gcnt1_o = 0 and glitch_o[1] pulses.
REQ-031 Reset mid-operation: rst during PENDING (run = 2) -> all outputs 0 the next cycle; no count recorded.
REQ-032 With GLITCH_SYNC_EN defined, the step in REQ-027 -> filt_o = 01 on the 5th edge after the change.
